// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM states and a
// two's-complement negation helper used for operand magnitudes and
// for re-applying result signs.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Helper operates on a wide container; callers zero/sign-extend their
    // WIDTH-bit values into it and take the low bits back out.
    localparam int MAXW = 128;

    function automatic logic [MAXW-1:0] cond_negate(input logic [MAXW-1:0] v,
                                                    input logic            neg);
        return neg ? ((~v) + MAXW'(1)) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the
// partial remainder, then subtract the divisor magnitude if it fits.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   p_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   p_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] d_ext;
    logic           unused_msb;

    // The incoming remainder is always below the divisor, so its top bit
    // is zero and only the low WIDTH bits take part in the shift.
    assign unused_msb = p_in[WIDTH];

    // Compare-and-subtract producing the new remainder and one quotient bit.
    always_comb begin
        shifted = {p_in[WIDTH-1:0], bit_in};
        d_ext   = {1'b0, d};
        p_out   = shifted;
        q_bit   = 1'b0;
        if (shifted >= d_ext) begin
            p_out = shifted - d_ext;
            q_bit = 1'b1;
        end
    end

endmodule

// File: rtl/div_engine.sv
// Multi-cycle WIDTH-bit integer divider, unsigned or signed per request.
// Operands are latched on an accepted start; one quotient bit is produced
// per clock, then a single fix-up cycle applies signs and publishes the
// result with a one-cycle done pulse. WIDTH must be at least 2.
module div_engine
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] N,
    input  logic [WIDTH-1:0] D,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int              CW      = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    state_t           state_next;

    logic [CW-1:0]    count;
    logic [WIDTH:0]   prem;
    logic [WIDTH:0]   prem_next;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] dmag;
    logic [WIDTH-1:0] nraw;
    logic             qneg;
    logic             rneg;
    logic             dzero;
    logic             ovfpend;
    logic             qbit;

    logic             accept;
    logic             step_en;
    logic             finish;

    logic             n_sign;
    logic             d_sign;
    logic [MAXW-1:0]  n_abs;
    logic [MAXW-1:0]  d_abs;
    logic [MAXW-1:0]  q_fix;
    logic [MAXW-1:0]  r_fix;
    logic             unused_bits;

    // Operand magnitudes: negative signed values are negated in a wide
    // container so that |MIN| is representable before truncation.
    assign n_sign = signed_mode & N[WIDTH-1];
    assign d_sign = signed_mode & D[WIDTH-1];
    assign n_abs  = cond_negate({{(MAXW-WIDTH){n_sign}}, N}, n_sign);
    assign d_abs  = cond_negate({{(MAXW-WIDTH){d_sign}}, D}, d_sign);

    // Sign re-application on the finished magnitudes; MIN / -1 wraps to
    // MIN naturally because the positive magnitude truncates to MIN.
    assign q_fix  = cond_negate({{(MAXW-WIDTH){1'b0}}, shreg}, qneg);
    assign r_fix  = cond_negate({{(MAXW-WIDTH){1'b0}}, prem[WIDTH-1:0]}, rneg);

    assign unused_bits = ^{n_abs[MAXW-1:WIDTH], d_abs[MAXW-1:WIDTH],
                           q_fix[MAXW-1:WIDTH], r_fix[MAXW-1:WIDTH]};

    assign busy = (state != IDLE);

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .p_in   (prem),
        .bit_in (shreg[WIDTH-1]),
        .d      (dmag),
        .p_out  (prem_next),
        .q_bit  (qbit)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and datapath control strobes.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        step_en    = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = (D == '0) ? FIX : CALC;
                end
            end
            CALC: begin
                step_en = 1'b1;
                if (count == LAST) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                finish     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand latch and iteration: the dividend register shifts out
    // dividend bits at the top while quotient bits shift in at the bottom.
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            prem    <= '0;
            shreg   <= '0;
            dmag    <= '0;
            nraw    <= '0;
            qneg    <= 1'b0;
            rneg    <= 1'b0;
            dzero   <= 1'b0;
            ovfpend <= 1'b0;
        end else if (accept) begin
            count   <= '0;
            prem    <= '0;
            shreg   <= n_abs[WIDTH-1:0];
            dmag    <= d_abs[WIDTH-1:0];
            nraw    <= N;
            qneg    <= n_sign ^ d_sign;
            rneg    <= n_sign;
            dzero   <= (D == '0);
            ovfpend <= signed_mode && (N == MIN_VAL) && (D == '1);
        end else if (step_en) begin
            count   <= count + CW'(1);
            prem    <= prem_next;
            shreg   <= {shreg[WIDTH-2:0], qbit};
        end
    end

    // Result registers, updated only in the fix-up cycle, plus done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            Q           <= '0;
            R           <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= finish;
            if (finish) begin
                if (dzero) begin
                    Q           <= '1;
                    R           <= nraw;
                    div_by_zero <= 1'b1;
                    overflow    <= 1'b0;
                end else begin
                    Q           <= q_fix[WIDTH-1:0];
                    R           <= r_fix[WIDTH-1:0];
                    div_by_zero <= 1'b0;
                    overflow    <= ovfpend;
                end
            end
        end
    end

endmodule

// File: tb/tb_div_engine.sv
// Self-checking bench for div_engine: directed scenarios on an 8-bit
// instance and a randomized sweep on a 16-bit instance, compared against
// a plain-arithmetic reference model.
module tb_div_engine;

    logic        clk = 1'b0;
    logic        rst;

    logic        start8, sm8, busy8, done8, dbz8, ovf8;
    logic [7:0]  n8, d8, q8, r8;

    logic        start16, sm16, busy16, done16, dbz16, ovf16;
    logic [15:0] n16, d16, q16, r16;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    div_engine #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .N(n8), .D(d8), .busy(busy8), .done(done8), .Q(q8), .R(r8),
        .div_by_zero(dbz8), .overflow(ovf8)
    );

    div_engine #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
        .N(n16), .D(d16), .busy(busy16), .done(done16), .Q(q16), .R(r16),
        .div_by_zero(dbz16), .overflow(ovf16)
    );

    // Reference: integer division with truncation toward zero on the
    // sign-interpreted operands, plus the divide-by-zero convention.
    function automatic void ref_div(input int w, input bit sm,
                                    input longint n_in, input longint d_in,
                                    output longint q, output longint r,
                                    output bit dbz, output bit ovf);
        longint mask, half, n, d, sn, sd;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        n = n_in & mask;
        d = d_in & mask;
        dbz = 1'b0;
        ovf = 1'b0;
        if (d == 0) begin
            q = mask;
            r = n;
            dbz = 1'b1;
        end else if (!sm) begin
            q = n / d;
            r = n % d;
        end else begin
            sn = (n >= half) ? n - (longint'(1) << w) : n;
            sd = (d >= half) ? d - (longint'(1) << w) : d;
            q = (sn / sd) & mask;
            r = (sn % sd) & mask;
            ovf = (sn == -half) && (sd == -1);
        end
    endfunction

    // Drive a one-cycle start from the current negedge; operands are
    // scrambled afterwards so only latched values can give a right answer.
    task automatic issue8(input bit sm, input logic [7:0] n, input logic [7:0] d);
        start8 = 1'b1; sm8 = sm; n8 = n; d8 = d;
        @(negedge clk);
        start8 = 1'b0; sm8 = ~sm; n8 = 8'($urandom); d8 = 8'($urandom);
    endtask

    // Wait for done, counting clocks since the start edge; optionally
    // pulse start at cycle pulse_at with unrelated operands.
    task automatic wait_done8(input int pulse_at, output int lat, output bit busy_ok);
        lat = -1;
        busy_ok = busy8;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start8 = (k == pulse_at);
            if (k == pulse_at) begin
                n8 = 8'hFF; d8 = 8'h01; sm8 = 1'b0;
            end
            if (done8) begin
                if (busy8) busy_ok = 1'b0;
                lat = k;
                break;
            end else if (!busy8) begin
                busy_ok = 1'b0;
            end
        end
        start8 = 1'b0;
    endtask

    task automatic run_op8(input bit sm, input logic [7:0] n, input logic [7:0] d,
                           output int lat, output bit busy_ok, output logic [17:0] got);
        @(negedge clk);
        issue8(sm, n, d);
        wait_done8(0, lat, busy_ok);
        got = {q8, r8, dbz8, ovf8};
    endtask

    task automatic run_op16(input bit sm, input logic [15:0] n, input logic [15:0] d,
                            output int lat, output logic [33:0] got);
        @(negedge clk);
        start16 = 1'b1; sm16 = sm; n16 = n; d16 = d;
        @(negedge clk);
        start16 = 1'b0; n16 = 16'($urandom); d16 = 16'($urandom);
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (done16) begin
                lat = k;
                break;
            end
        end
        got = {q16, r16, dbz16, ovf16};
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start8 = 1'b0; sm8 = 1'b0; n8 = '0; d8 = '0;
        start16 = 1'b0; sm16 = 1'b0; n16 = '0; d16 = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy8, done8, q8, r8, dbz8, ovf8} !== 20'h0) begin
            n_bad++;
            $display("[TB] FAIL reset8: got %h expected 0", {busy8, done8, q8, r8, dbz8, ovf8});
        end
        n_cmp++;
        if ({busy16, done16, q16, r16, dbz16, ovf16} !== 36'h0) begin
            n_bad++;
            $display("[TB] FAIL reset16: got %h expected 0", {busy16, done16, q16, r16, dbz16, ovf16});
        end
        rst = 1'b0;
    endtask

    task automatic test_unsigned_basic;
        int lat; bit bok; logic [17:0] got;
        run_op8(1'b0, 8'd32, 8'd3, lat, bok, got);
        n_cmp++;
        if (lat !== 9) begin
            n_bad++; $display("[TB] FAIL u32div3_latency: got %0d expected 9", lat);
        end
        n_cmp++;
        if (got !== {8'd10, 8'd2, 1'b0, 1'b0}) begin
            n_bad++; $display("[TB] FAIL u32div3_result: got %h expected %h", got, {8'd10, 8'd2, 2'b00});
        end
        n_cmp++;
        if (bok !== 1'b1) begin
            n_bad++; $display("[TB] FAIL u32div3_busy: got %b expected 1", bok);
        end
    endtask

    task automatic test_signed;
        int lat; bit bok; logic [17:0] got;
        run_op8(1'b1, 8'hF9, 8'h02, lat, bok, got);
        n_cmp++;
        if (got !== {8'hFD, 8'hFF, 2'b00}) begin
            n_bad++; $display("[TB] FAIL s_m7div2: got %h expected %h", got, {8'hFD, 8'hFF, 2'b00});
        end
        run_op8(1'b1, 8'h07, 8'hFE, lat, bok, got);
        n_cmp++;
        if (got !== {8'hFD, 8'h01, 2'b00}) begin
            n_bad++; $display("[TB] FAIL s_7divm2: got %h expected %h", got, {8'hFD, 8'h01, 2'b00});
        end
        n_cmp++;
        if (lat !== 9 || bok !== 1'b1) begin
            n_bad++; $display("[TB] FAIL s_timing: got lat %0d busy_ok %b expected 9 1", lat, bok);
        end
    endtask

    task automatic test_div_zero;
        int lat; bit bok; logic [17:0] got;
        run_op8(1'b0, 8'd200, 8'd0, lat, bok, got);
        n_cmp++;
        if (lat !== 1) begin
            n_bad++; $display("[TB] FAIL dz_latency: got %0d expected 1", lat);
        end
        n_cmp++;
        if (got !== {8'hFF, 8'd200, 2'b10}) begin
            n_bad++; $display("[TB] FAIL dz_unsigned: got %h expected %h", got, {8'hFF, 8'd200, 2'b10});
        end
        run_op8(1'b0, 8'd100, 8'd7, lat, bok, got);
        n_cmp++;
        if (got !== {8'd14, 8'd2, 2'b00}) begin
            n_bad++; $display("[TB] FAIL dz_clear: got %h expected %h", got, {8'd14, 8'd2, 2'b00});
        end
        run_op8(1'b1, 8'hFB, 8'd0, lat, bok, got);
        n_cmp++;
        if (got !== {8'hFF, 8'hFB, 2'b10} || lat !== 1) begin
            n_bad++; $display("[TB] FAIL dz_signed: got %h lat %0d expected %h lat 1", got, lat, {8'hFF, 8'hFB, 2'b10});
        end
    endtask

    task automatic test_overflow;
        int lat; bit bok; logic [17:0] got;
        run_op8(1'b1, 8'h80, 8'hFF, lat, bok, got);
        n_cmp++;
        if (got !== {8'h80, 8'h00, 2'b01}) begin
            n_bad++; $display("[TB] FAIL ovf_signed: got %h expected %h", got, {8'h80, 8'h00, 2'b01});
        end
        run_op8(1'b0, 8'h80, 8'hFF, lat, bok, got);
        n_cmp++;
        if (got !== {8'h00, 8'h80, 2'b00}) begin
            n_bad++; $display("[TB] FAIL ovf_unsigned: got %h expected %h", got, {8'h00, 8'h80, 2'b00});
        end
        run_op8(1'b0, 8'h80, 8'h01, lat, bok, got);
        n_cmp++;
        if (got !== {8'h80, 8'h00, 2'b00}) begin
            n_bad++; $display("[TB] FAIL min_div1_unsigned: got %h expected %h", got, {8'h80, 8'h00, 2'b00});
        end
    endtask

    task automatic test_ignore_start;
        int lat; bit bok; logic [17:0] got;
        @(negedge clk);
        issue8(1'b0, 8'd250, 8'd7);
        wait_done8(3, lat, bok);
        got = {q8, r8, dbz8, ovf8};
        n_cmp++;
        if (got !== {8'd35, 8'd5, 2'b00} || lat !== 9) begin
            n_bad++; $display("[TB] FAIL ignore_start: got %h lat %0d expected %h lat 9", got, lat, {8'd35, 8'd5, 2'b00});
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy8, done8} !== 2'b00) begin
            n_bad++; $display("[TB] FAIL ignore_start_idle: got busy/done %b expected 00", {busy8, done8});
        end
    endtask

    task automatic test_back_to_back;
        int lat; bit bok; logic [17:0] got;
        run_op8(1'b0, 8'd77, 8'd5, lat, bok, got);
        n_cmp++;
        if (got !== {8'd15, 8'd2, 2'b00}) begin
            n_bad++; $display("[TB] FAIL b2b_first: got %h expected %h", got, {8'd15, 8'd2, 2'b00});
        end
        issue8(1'b1, 8'h9C, 8'h07);
        wait_done8(0, lat, bok);
        got = {q8, r8, dbz8, ovf8};
        n_cmp++;
        if (got !== {8'hF2, 8'hFE, 2'b00} || lat !== 9) begin
            n_bad++; $display("[TB] FAIL b2b_second: got %h lat %0d expected %h lat 9", got, lat, {8'hF2, 8'hFE, 2'b00});
        end
    endtask

    task automatic test_reset_mid;
        int lat; bit bok; logic [17:0] got;
        bit saw_done;
        run_op8(1'b0, 8'd200, 8'd0, lat, bok, got);
        @(negedge clk);
        issue8(1'b0, 8'd250, 8'd7);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({busy8, done8, q8, r8, dbz8, ovf8} !== 20'h0) begin
            n_bad++; $display("[TB] FAIL reset_mid: got %h expected 0", {busy8, done8, q8, r8, dbz8, ovf8});
        end
        saw_done = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done8 || busy8) saw_done = 1'b1;
        end
        n_cmp++;
        if (saw_done !== 1'b0) begin
            n_bad++; $display("[TB] FAIL reset_mid_nodone: got activity %b expected 0", saw_done);
        end
    endtask

    task automatic test_random8;
        int lat; bit bok; logic [17:0] got, exp;
        longint eq, er; bit edz, eov;
        logic [7:0] n, d; bit sm;
        for (int i = 0; i < 40; i++) begin
            sm = 1'($urandom);
            n  = 8'($urandom);
            d  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            if (i % 10 == 0) begin n = 8'h80; d = 8'hFF; end
            ref_div(8, sm, longint'(n), longint'(d), eq, er, edz, eov);
            exp = {8'(eq), 8'(er), edz, eov};
            run_op8(sm, n, d, lat, bok, got);
            n_cmp++;
            if (got !== exp || lat !== ((d == 0) ? 1 : 9) || bok !== 1'b1) begin
                n_bad++;
                $display("[TB] FAIL rand8 sm=%b %h/%h: got %h lat %0d busy_ok %b expected %h", sm, n, d, got, lat, bok, exp);
            end
        end
    endtask

    task automatic test_random16;
        int lat; logic [33:0] got, exp;
        longint eq, er; bit edz, eov;
        logic [15:0] n, d; bit sm;
        for (int i = 0; i < 120; i++) begin
            sm = (i >= 60);
            n  = 16'($urandom);
            case ($urandom_range(0, 9))
                0: d = 16'h0000;
                1: d = 16'hFFFF;
                2: d = 16'($urandom_range(1, 15));
                default: d = 16'($urandom);
            endcase
            if (i == 70) begin n = 16'h8000; d = 16'hFFFF; end
            ref_div(16, sm, longint'(n), longint'(d), eq, er, edz, eov);
            exp = {16'(eq), 16'(er), edz, eov};
            run_op16(sm, n, d, lat, got);
            n_cmp++;
            if (got !== exp || lat !== ((d == 0) ? 1 : 17)) begin
                n_bad++;
                $display("[TB] FAIL rand16 sm=%b %h/%h: got %h lat %0d expected %h", sm, n, d, got, lat, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_basic();
        test_signed();
        test_div_zero();
        test_overflow();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random8();
        test_random16();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Watchdog so a stuck design still ends the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
